mdio_phy_responder: RTL and testbench
=====================================

Name: mdio_phy_responder

Overview:
- PHY-side MDIO management responder: the slave end of the station-management link driven by mac_controller (phy_mdc / phy_mdio).
- Decodes IEEE 802.3 Clause 22 frames sampled from MDC/MDIO and holds a 32 x 16-bit PHY register file.
- Drives read data back onto MDIO through a tri-state output-enable pair.
- Used as the PHY model in MDIO benches and as the register front end of a soft PHY.

Parameters:
- PHY_ADDR, 5'd1, PHY address this responder answers to.
- PREAMBLE_LEN, 32, minimum consecutive 1 bits that qualify a preamble.
- PHY_ID1, 16'h0141, reset and read-only value of register 2.
- PHY_ID2, 16'h0CC2, reset and read-only value of register 3.

Ports:
- clk, input, 1, system clock; MDC is oversampled on this clock.
- rst, input, 1, asynchronous active-high reset.
- mdc, input, 1, MDIO clock from the station; asynchronous to clk.
- mdio_i, input, 1, MDIO line value, sampled.
- mdio_o, output, 1, MDIO value driven by the responder.
- mdio_oe, output, 1, 1 = responder drives MDIO.
- wr_strobe, output, 1, one-clk pulse when a write frame to PHY_ADDR completes.
- wr_regad, output, 5, register address of the last completed write.
- wr_data, output, 16, data of the last completed write.
- rd_strobe, output, 1, one-clk pulse when a read frame to PHY_ADDR completes.
- frame_err, output, 1, one-clk pulse on an invalid start, opcode or turnaround.
- ctrl_reg, output, 16, live value of register 0.

Behaviour:
- Reset (async, rst=1):
  - mdio_o=0, mdio_oe=0; all strobes 0; wr_regad=0, wr_data=0.
  - FSM=IDLE; preamble count=0.
  - Registers: reg0=16'h1140, reg1=16'h7949, reg2=PHY_ID1, reg3=PHY_ID2, reg4..31=0.
- MDC handling:
  - mdc passes through a 2-FF synchronizer; the rising edge is detected one clk later.
  - Every action happens on a detected MDC rise ("edge"), and mdio_i is sampled through the same synchronizer depth.
  - The design requires MDC high and low times of at least 4 clk each.
- Bit order: all fields MSB first. Outputs change on the edge that ends a bit period, so each value is valid for the whole following MDC period.
- FSM states and transitions:
  - IDLE:
    - Each sampled 1 increments the preamble count, saturating at PREAMBLE_LEN.
    - A 0 with count = PREAMBLE_LEN goes to ST1.
    - A 0 with count below PREAMBLE_LEN clears the count.
  - ST1: a 1 goes to OP. A 0 pulses frame_err and returns to IDLE with count 0.
  - OP: 2 bits. 10 = read, 01 = write. 00 or 11 pulses frame_err and returns to IDLE.
  - PHYAD: 5 bits. A mismatch with PHY_ADDR sets a skip flag; mdio_oe stays 0 for the rest of the frame.
  - REGAD: 5 bits.
  - TA: 2 bit periods.
    - Read, not skipped: mdio_oe stays 0 in period 1. The edge ending period 1 sets mdio_oe=1, mdio_o=0. The edge ending period 2 drives data bit 15.
    - Write: period 1 must sample 1, otherwise frame_err is pulsed and the FSM returns to IDLE. Period 2 is ignored.
  - DATA: 16 bits.
    - Read: the read value is latched at the edge entering TA. Each edge shifts the next bit out. The edge ending bit 0 sets mdio_oe=0 and pulses rd_strobe for one clk.
    - Write: the edge sampling bit 0 commits the register on that clk, pulses wr_strobe, and updates wr_regad and wr_data.
    - Either direction then returns to IDLE with count 0. Back-to-back frames need a new preamble.
- Register rules:
  - reg1..3 are read-only: writes are discarded, but wr_strobe still pulses.
  - reg0 bit15 is self-clearing soft reset. Writing 1 reloads all registers to reset values on the next clk; bit15 then reads 0.
  - Writes to skipped (mismatched-address) frames have no effect and produce no strobes.
- Reset mid-frame: mdio_oe drops to 0 immediately (async); the FSM returns to IDLE.

Optional Feature:
- Macro MDIO_PREAMBLE_SUPPRESS_EN.
- Defined: in IDLE, a 0 with any preamble count (including 0) starts ST1. This gives Clause 22 preamble suppression and allows back-to-back frames with no preamble.
- Undefined: exactly the PREAMBLE_LEN rule above.

Test Plan:
- 32 ones + write frame to phy 1, reg 0, data 16'h3100 -> wr_strobe pulse; wr_regad=0; wr_data=16'h3100; ctrl_reg=16'h3100; mdio_oe never 1.
- Preamble + read from phy 1, reg 2 -> mdio_oe rises at TA period 2 with mdio_o=0; serial data 16'h0141; mdio_oe falls after bit 0; rd_strobe pulse.
- Read to phy 5 -> mdio_oe stays 0 the whole frame; no strobes; the next valid frame decodes normally.
- 31 ones + start -> frame ignored without the macro; with MDIO_PREAMBLE_SUPPRESS_EN, a write of 16'h00AA to reg 4 reads back 16'h00AA.
- Opcode 11 -> frame_err pulse. Write 16'h8000 to reg 0 -> ctrl_reg returns to 16'h1140 on the next clk.
- rst asserted during read DATA bit 7 -> mdio_oe=0 in the same clk; the FSM is IDLE; a following read returns the reset values.

Source files
------------

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause 22 MDIO PHY responder with 32x16 register file; define MDIO_PREAMBLE_SUPPRESS_EN to accept frames without preamble
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int          PREAMBLE_LEN = 32,
    parameter logic [15:0] PHY_ID1      = 16'h0141,
    parameter logic [15:0] PHY_ID2      = 16'h0CC2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        wr_strobe,
    output logic [4:0]  wr_regad,
    output logic [15:0] wr_data,
    output logic        rd_strobe,
    output logic        frame_err,
    output logic [15:0] ctrl_reg
);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic SUPPRESS = 1'b1;
`else
    localparam logic SUPPRESS = 1'b0;
`endif
    localparam int PW = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PW-1:0] PMAX = PW'(PREAMBLE_LEN);
    typedef enum logic [2:0] {IDLE, ST1, OP, PHYAD, REGAD, TA, DATA} state_t;
    state_t state, state_n;
    logic [1:0] mdc_s, mdio_s;
    logic mdc_d, mdc_rise, din, last;
    logic [PW-1:0] pre_cnt;
    logic [3:0] cnt, phy;
    logic [4:0] regad;
    logic op0, is_rd, skip;
    logic [15:0] sh, wd;
    logic [15:0] regs [32];
    logic err_n, wr_n, rd_n, oe_n, o_n;
    assign mdc_rise = mdc_s[1] & ~mdc_d;
    assign din = mdio_s[1];
    assign last = cnt == 4'd15;
    assign wd = {sh[14:0], din};
    assign ctrl_reg = regs[0];
    function automatic logic [15:0] rst_val(input int i);
        return i == 0 ? 16'h1140 : i == 1 ? 16'h7949 : i == 2 ? PHY_ID1 : i == 3 ? PHY_ID2 : 16'h0;
    endfunction
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    always_comb begin
        state_n = state;
        if (mdc_rise)
            case (state)
                IDLE:    state_n = (!din && (SUPPRESS || pre_cnt == PMAX)) ? ST1 : IDLE;
                ST1:     state_n = din ? OP : IDLE;
                OP:      state_n = !cnt[0] ? OP : (op0 != din) ? PHYAD : IDLE;
                PHYAD:   state_n = cnt == 4'd4 ? REGAD : PHYAD;
                REGAD:   state_n = cnt == 4'd4 ? TA : REGAD;
                TA:      state_n = (!cnt[0] && !is_rd && !din) ? IDLE : cnt[0] ? DATA : TA;
                DATA:    state_n = last ? IDLE : DATA;
                default: state_n = IDLE;
            endcase
    end
    always_comb begin
        err_n = 1'b0;
        wr_n = 1'b0;
        rd_n = 1'b0;
        oe_n = mdio_oe;
        o_n = mdio_o;
        if (mdc_rise)
            case (state)
                ST1: err_n = !din;
                OP:  err_n = cnt[0] && op0 == din;
                TA: begin
                    err_n = !cnt[0] && !is_rd && !din;
                    oe_n = is_rd && !skip;
                    o_n = cnt[0] && is_rd && !skip && sh[15];
                end
                DATA: begin
                    wr_n = last && !is_rd && !skip;
                    rd_n = last && is_rd && !skip;
                    oe_n = !last && is_rd && !skip;
                    o_n = !last && is_rd && !skip && sh[15];
                end
                default: ;
            endcase
    end
    // Field shift registers load on every edge of their state; only the final edge's value matters.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mdc_s <= '0;
            mdio_s <= '0;
            mdc_d <= 1'b0;
            pre_cnt <= '0;
            cnt <= '0;
            phy <= '0;
            regad <= '0;
            op0 <= 1'b0;
            is_rd <= 1'b0;
            skip <= 1'b0;
            sh <= '0;
            mdio_o <= 1'b0;
            mdio_oe <= 1'b0;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_regad <= '0;
            wr_data <= '0;
        end else begin
            mdc_s <= {mdc_s[0], mdc};
            mdio_s <= {mdio_s[0], mdio_i};
            mdc_d <= mdc_s[1];
            mdio_o <= o_n;
            mdio_oe <= oe_n;
            wr_strobe <= wr_n;
            rd_strobe <= rd_n;
            frame_err <= err_n;
            if (wr_n) begin
                wr_regad <= regad;
                wr_data <= wd;
            end
            if (mdc_rise) begin
                cnt <= state_n != state ? 4'd0 : cnt + 4'd1;
                if (state == IDLE)
                    pre_cnt <= !din ? '0 : pre_cnt == PMAX ? pre_cnt : pre_cnt + PW'(1);
                if (state == OP) begin
                    op0 <= din;
                    is_rd <= op0;
                end
                if (state == PHYAD) begin
                    phy <= {phy[2:0], din};
                    skip <= {phy, din} != PHY_ADDR;
                end
                if (state == REGAD) begin
                    regad <= {regad[3:0], din};
                    sh <= regs[{regad[3:0], din}];
                end
                if ((state == TA && cnt[0]) || state == DATA)
                    sh <= {sh[14:0], din};
            end
        end
    // Soft reset: a committed reg0 bit15 reloads every register on the following clk.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < 32; i++)
                regs[i] <= rst_val(i);
        else if (regs[0][15])
            for (int i = 0; i < 32; i++)
                regs[i] <= rst_val(i);
        else if (wr_n && (regad == 5'd0 || regad > 5'd3))
            regs[regad] <= wd;
endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder: directed MDIO frame bench for mdio_phy_responder
module tb_mdio_phy_responder;
    localparam logic [1:0] RD = 2'b10, WR = 2'b01, TA_RD = 2'b11, TA_WR = 2'b10;
    logic clk, rst, mdc, mdio_i, mdio_o, mdio_oe, wr_strobe, rd_strobe, frame_err;
    logic [4:0] wr_regad;
    logic [15:0] wr_data, ctrl_reg, rd_val, ctrl_wr, ctrl_nxt;
    logic s_oe, s_o, oe_ta1, oe_ta2, o_ta2, oe_data, oe_end, wr_q;
    int n_cmp, n_err, wr_tot, rd_tot, err_tot, oe_tot, b_wr, b_rd, b_err, b_oe;
    mdio_phy_responder dut (
        .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
        .wr_strobe(wr_strobe), .wr_regad(wr_regad), .wr_data(wr_data), .rd_strobe(rd_strobe),
        .frame_err(frame_err), .ctrl_reg(ctrl_reg)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        wr_tot = 0;
        rd_tot = 0;
        err_tot = 0;
        oe_tot = 0;
        wr_q = 1'b0;
        ctrl_wr = '0;
        ctrl_nxt = '0;
    end
    always @(negedge clk) begin
        if (wr_strobe) begin
            wr_tot++;
            ctrl_wr = ctrl_reg;
        end
        if (wr_q)
            ctrl_nxt = ctrl_reg;
        wr_q = wr_strobe;
        if (rd_strobe)
            rd_tot++;
        if (frame_err)
            err_tot++;
        if (mdio_oe)
            oe_tot++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic mark();
        b_wr = wr_tot;
        b_rd = rd_tot;
        b_err = err_tot;
        b_oe = oe_tot;
    endtask
    task automatic send_bit(input logic b);
        mdc = 1'b0;
        mdio_i = b;
        wait_clk(8);
        s_oe = mdio_oe;
        s_o = mdio_o;
        mdc = 1'b1;
        wait_clk(8);
    endtask
    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [1:0] ta, input logic [15:0] wd, input int abort);
        logic [13:0] hdr;
        hdr = {2'b01, op, pa, ra};
        mark();
        for (int i = 0; i < pre; i++)
            send_bit(1'b1);
        for (int i = 13; i >= 10; i--)
            send_bit(hdr[i]);
        if (op == 2'b00 || op == 2'b11)
            return;
        for (int i = 9; i >= 0; i--)
            send_bit(hdr[i]);
        send_bit(ta[1]);
        oe_ta1 = s_oe;
        if (op == WR && !ta[1])
            return;
        send_bit(ta[0]);
        oe_ta2 = s_oe;
        o_ta2 = s_o;
        oe_data = 1'b1;
        rd_val = '0;
        for (int i = 15; i >= 0; i--) begin
            if (i == abort) begin
                mdc = 1'b0;
                wait_clk(4);
                check("oe_before_rst", 32'(mdio_oe), 1);
                rst = 1'b1;
                #1;
                check("oe_async_rst", 32'(mdio_oe), 0);
                wait_clk(4);
                rst = 1'b0;
                mdio_i = 1'b1;
                mdc = 1'b1;
                wait_clk(8);
                return;
            end
            send_bit(op == RD ? 1'b1 : wd[i]);
            oe_data &= s_oe;
            rd_val[i] = s_o;
        end
        oe_end = mdio_oe;
    endtask
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        mdc = 1'b1;
        mdio_i = 1'b1;
        wait_clk(3);
        check("rst_oe", 32'(mdio_oe), 0);
        check("rst_o", 32'(mdio_o), 0);
        check("rst_strobes", 32'({wr_strobe, rd_strobe, frame_err}), 0);
        check("rst_wr_regad", 32'(wr_regad), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_ctrl", 32'(ctrl_reg), 32'h1140);
        rst = 1'b0;
        wait_clk(8);
        frame(32, WR, 5'd1, 5'd0, TA_WR, 16'h3100, -1);
        check("w0_strobe", wr_tot - b_wr, 1);
        check("w0_regad", 32'(wr_regad), 0);
        check("w0_data", 32'(wr_data), 32'h3100);
        check("w0_ctrl", 32'(ctrl_reg), 32'h3100);
        check("w0_ctrl_at_strobe", 32'(ctrl_wr), 32'h3100);
        check("w0_no_oe", oe_tot - b_oe, 0);
        frame(32, RD, 5'd1, 5'd2, TA_RD, 16'h0, -1);
        check("r2_data", 32'(rd_val), 32'h0141);
        check("r2_oe_ta1", 32'(oe_ta1), 0);
        check("r2_oe_ta2", 32'(oe_ta2), 1);
        check("r2_o_ta2", 32'(o_ta2), 0);
        check("r2_oe_data", 32'(oe_data), 1);
        check("r2_oe_end", 32'(oe_end), 0);
        check("r2_rd_strobe", rd_tot - b_rd, 1);
        check("r2_no_wr", wr_tot - b_wr, 0);
        frame(32, RD, 5'd1, 5'd1, TA_RD, 16'h0, -1);
        check("r1_data", 32'(rd_val), 32'h7949);
        frame(32, RD, 5'd1, 5'd3, TA_RD, 16'h0, -1);
        check("r3_data", 32'(rd_val), 32'h0CC2);
        frame(32, RD, 5'd5, 5'd2, TA_RD, 16'h0, -1);
        check("p5_rd_no_oe", oe_tot - b_oe, 0);
        check("p5_rd_no_rd", rd_tot - b_rd, 0);
        check("p5_rd_no_wr", wr_tot - b_wr, 0);
        frame(32, WR, 5'd5, 5'd4, TA_WR, 16'h1234, -1);
        check("p5_wr_no_wr", wr_tot - b_wr, 0);
        frame(32, RD, 5'd1, 5'd4, TA_RD, 16'h0, -1);
        check("r4_after_skip", 32'(rd_val), 0);
        check("r4_rd_strobe", rd_tot - b_rd, 1);
        frame(32, WR, 5'd1, 5'd2, TA_WR, 16'hFFFF, -1);
        check("ro_wr_strobe", wr_tot - b_wr, 1);
        check("ro_wr_regad", 32'(wr_regad), 2);
        check("ro_wr_data", 32'(wr_data), 32'hFFFF);
        frame(32, RD, 5'd1, 5'd2, TA_RD, 16'h0, -1);
        check("ro_readback", 32'(rd_val), 32'h0141);
        frame(31, WR, 5'd1, 5'd4, TA_WR, 16'h00AA, -1);
        check("pre31_no_err", err_tot - b_err, 0);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        check("pre31_wr", wr_tot - b_wr, 1);
        frame(32, RD, 5'd1, 5'd4, TA_RD, 16'h0, -1);
        check("pre31_readback", 32'(rd_val), 32'h00AA);
`else
        check("pre31_wr", wr_tot - b_wr, 0);
        frame(32, RD, 5'd1, 5'd4, TA_RD, 16'h0, -1);
        check("pre31_readback", 32'(rd_val), 0);
`endif
        frame(32, 2'b11, 5'd1, 5'd0, TA_RD, 16'h0, -1);
        check("op11_err", err_tot - b_err, 1);
        check("op11_no_strobe", (wr_tot - b_wr) + (rd_tot - b_rd), 0);
        frame(32, 2'b00, 5'd1, 5'd0, TA_RD, 16'h0, -1);
        check("op00_err", err_tot - b_err, 1);
        mark();
        for (int i = 0; i < 32; i++)
            send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        check("st1_err", err_tot - b_err, 1);
        frame(32, WR, 5'd1, 5'd4, 2'b00, 16'h5A5A, -1);
        check("ta_err", err_tot - b_err, 1);
        check("ta_err_no_wr", wr_tot - b_wr, 0);
        frame(32, WR, 5'd1, 5'd4, TA_WR, 16'h5555, -1);
        frame(32, RD, 5'd1, 5'd4, TA_RD, 16'h0, -1);
        check("r4_5555", 32'(rd_val), 32'h5555);
        frame(32, WR, 5'd1, 5'd0, TA_WR, 16'h8000, -1);
        check("srst_ctrl_at_strobe", 32'(ctrl_wr), 32'h8000);
        check("srst_ctrl_next", 32'(ctrl_nxt), 32'h1140);
        check("srst_ctrl", 32'(ctrl_reg), 32'h1140);
        frame(32, RD, 5'd1, 5'd4, TA_RD, 16'h0, -1);
        check("srst_r4", 32'(rd_val), 0);
        frame(32, WR, 5'd1, 5'd5, TA_WR, 16'hBEEF, -1);
        frame(32, WR, 5'd1, 5'd0, TA_WR, 16'h2100, -1);
        check("pre_abort_ctrl", 32'(ctrl_reg), 32'h2100);
        frame(32, RD, 5'd1, 5'd0, TA_RD, 16'h0, 7);
        check("abort_ctrl", 32'(ctrl_reg), 32'h1140);
        frame(32, RD, 5'd1, 5'd0, TA_RD, 16'h0, -1);
        check("abort_r0", 32'(rd_val), 32'h1140);
        check("abort_rd_strobe", rd_tot - b_rd, 1);
        frame(32, RD, 5'd1, 5'd5, TA_RD, 16'h0, -1);
        check("abort_r5", 32'(rd_val), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
